// File: rtl/id_pkg.sv
// -----------------------------------------------------------------------------
// id_pkg
// Shared types and constants for the ID/EX pipeline register and its hazard
// logic.
//   state_e         : control state of the ID/EX register (RUN / STALL / HALT)
//   REG_ZERO        : index of the hard-wired zero register
//   CTRL_W_DEFAULT  : default width of the packed control bundle
//   CTRL_BUBBLE     : control bundle of a bubble (no side effects, all zeros)
//   CNT_W           : width of the multi-bubble stall counter (up to 7 bubbles)
// -----------------------------------------------------------------------------
package id_pkg;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_STALL = 2'd1,
    ST_HALT  = 2'd2
  } state_e;

  localparam int REG_ZERO       = 0;
  localparam int CTRL_W_DEFAULT = 24;
  localparam logic [CTRL_W_DEFAULT-1:0] CTRL_BUBBLE = '0;
  localparam int CNT_W          = $clog2(8);

endpackage

// File: rtl/id_ex_hazard_reg_load_use_detector.sv
// -----------------------------------------------------------------------------
// load_use_detector
// Combinational load-use hazard term: the instruction in ID reads a register
// that the load currently in EX has not written yet. Kept separate so the
// forwarding unit can share it.
// Ports:
//   i_id_valid                 : ID holds a real instruction
//   i_id_rs, i_id_rt           : ID source selects
//   i_id_uses_rs, i_id_uses_rt : ID actually reads rs / rt
//   i_ex_valid                 : EX holds a real instruction
//   i_ex_mem_rd                : EX instruction is a load
//   i_ex_rd_dst                : EX destination register
//   o_hazard                   : load-use hazard present
// -----------------------------------------------------------------------------
module load_use_detector
  import id_pkg::*;
#(
  parameter int REG_SEL_W = 5
) (
  input  logic                 i_id_valid,
  input  logic [REG_SEL_W-1:0] i_id_rs,
  input  logic [REG_SEL_W-1:0] i_id_rt,
  input  logic                 i_id_uses_rs,
  input  logic                 i_id_uses_rt,
  input  logic                 i_ex_valid,
  input  logic                 i_ex_mem_rd,
  input  logic [REG_SEL_W-1:0] i_ex_rd_dst,
  output logic                 o_hazard
);

  logic w_dst_nonzero;
  logic w_rs_match;
  logic w_rt_match;

  // Writes to the zero register are discarded, so they never create a hazard.
  assign w_dst_nonzero = (i_ex_rd_dst != REG_SEL_W'(REG_ZERO));
  assign w_rs_match    = i_id_uses_rs && (i_id_rs == i_ex_rd_dst);
  assign w_rt_match    = i_id_uses_rt && (i_id_rt == i_ex_rd_dst);

  assign o_hazard = i_id_valid && i_ex_valid && i_ex_mem_rd && w_dst_nonzero
                    && (w_rs_match || w_rt_match);

endmodule

// File: rtl/id_ex_hazard_reg.sv
// -----------------------------------------------------------------------------
// id_ex_hazard_reg
// Decode-to-execute pipeline register with load-use stall, branch flush and
// HALT freeze.
// Optional build macro: HAZARD_PERF_EN (enables the saturating bubble counter
// on o_bubble_cnt; when undefined o_bubble_cnt is constant 0).
// Ports:
//   i_clk, i_rst (async, active-low)  : clock / reset
//   i_step                            : advance enable, state changes only when 1
//   i_flush                           : kill ID/EX contents (taken jump/branch)
//   i_id_*                            : decoded ID instruction fields
//   o_stall_if_id                     : hold PC and IF/ID (combinational)
//   o_ex_*                            : registered EX-stage fields
//   o_halted                          : pipe frozen by HALT
//   o_bubble_cnt                      : hazard/stall bubble count
// -----------------------------------------------------------------------------
module id_ex_hazard_reg
  import id_pkg::*;
#(
  parameter int NBITS            = 32,
  parameter int REG_SEL_W        = 5,
  parameter int CTRL_W           = CTRL_W_DEFAULT,
  parameter int LOAD_USE_BUBBLES = 1
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_step,
  input  logic                 i_flush,
  input  logic                 i_id_valid,
  input  logic [REG_SEL_W-1:0] i_id_rs,
  input  logic [REG_SEL_W-1:0] i_id_rt,
  input  logic                 i_id_uses_rs,
  input  logic                 i_id_uses_rt,
  input  logic [REG_SEL_W-1:0] i_id_rd_dst,
  input  logic                 i_id_mem_rd,
  input  logic                 i_id_halt,
  input  logic [CTRL_W-1:0]    i_id_ctrl,
  input  logic [NBITS-1:0]     i_id_src_a,
  input  logic [NBITS-1:0]     i_id_src_b,
  input  logic [NBITS-1:0]     i_id_agu_addr,
  output logic                 o_stall_if_id,
  output logic                 o_ex_valid,
  output logic [CTRL_W-1:0]    o_ex_ctrl,
  output logic [NBITS-1:0]     o_ex_src_a,
  output logic [NBITS-1:0]     o_ex_src_b,
  output logic [NBITS-1:0]     o_ex_agu_addr,
  output logic [REG_SEL_W-1:0] o_ex_rd_dst,
  output logic                 o_ex_mem_rd,
  output logic                 o_ex_halt,
  output logic                 o_halted,
  output logic [15:0]          o_bubble_cnt
);

  localparam logic [CNT_W-1:0] LUB_RELOAD = CNT_W'(LOAD_USE_BUBBLES - 1);

  state_e               r_state;
  logic [CNT_W-1:0]     r_cnt;
  logic                 r_ex_valid;
  logic [CTRL_W-1:0]    r_ex_ctrl;
  logic [NBITS-1:0]     r_ex_src_a;
  logic [NBITS-1:0]     r_ex_src_b;
  logic [NBITS-1:0]     r_ex_agu_addr;
  logic [REG_SEL_W-1:0] r_ex_rd_dst;
  logic                 r_ex_mem_rd;
  logic                 r_ex_halt;

  state_e               w_next_state;
  logic [CNT_W-1:0]     w_next_cnt;
  logic                 w_stall;
  logic                 w_load_bubble;
  logic                 w_count_bubble;
  logic                 w_hazard;

  load_use_detector #(
    .REG_SEL_W(REG_SEL_W)
  ) u_detector (
    .i_id_valid  (i_id_valid),
    .i_id_rs     (i_id_rs),
    .i_id_rt     (i_id_rt),
    .i_id_uses_rs(i_id_uses_rs),
    .i_id_uses_rt(i_id_uses_rt),
    .i_ex_valid  (r_ex_valid),
    .i_ex_mem_rd (r_ex_mem_rd),
    .i_ex_rd_dst (r_ex_rd_dst),
    .o_hazard    (w_hazard)
  );

  always_comb begin
    w_next_state   = r_state;
    w_next_cnt     = r_cnt;
    w_stall        = 1'b0;
    w_load_bubble  = 1'b0;
    w_count_bubble = 1'b0;
    // Flush only acts on a step edge; without a step the stall output keeps
    // reflecting the held state.
    if (i_flush && i_step && (r_state != ST_HALT)) begin
      w_load_bubble = 1'b1;
      w_next_cnt    = '0;
      w_next_state  = ST_RUN;
    end else begin
      unique case (r_state)
        ST_RUN: begin
          if (r_ex_valid && r_ex_halt) begin
            // HALT has reached EX: freeze, and keep younger instructions out.
            w_load_bubble = 1'b1;
            w_next_state  = ST_HALT;
          end else if (w_hazard) begin
            w_stall        = 1'b1;
            w_load_bubble  = 1'b1;
            w_count_bubble = 1'b1;
            // A single bubble needs no counter: the bubble in EX stops re-detection.
            if (LOAD_USE_BUBBLES > 1) begin
              w_next_cnt   = LUB_RELOAD;
              w_next_state = ST_STALL;
            end
          end
        end
        ST_STALL: begin
          w_stall        = 1'b1;
          w_load_bubble  = 1'b1;
          w_count_bubble = 1'b1;
          w_next_cnt     = r_cnt - CNT_W'(1);
          if (r_cnt == CNT_W'(1)) begin
            w_next_state = ST_RUN;
          end
        end
        ST_HALT: begin
          w_stall       = 1'b1;
          w_load_bubble = 1'b1;
        end
        default: begin
          w_load_bubble = 1'b1;
          w_next_state  = ST_RUN;
        end
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_state       <= ST_RUN;
      r_cnt         <= '0;
      r_ex_valid    <= 1'b0;
      r_ex_ctrl     <= '0;
      r_ex_src_a    <= '0;
      r_ex_src_b    <= '0;
      r_ex_agu_addr <= '0;
      r_ex_rd_dst   <= '0;
      r_ex_mem_rd   <= 1'b0;
      r_ex_halt     <= 1'b0;
    end else if (i_step) begin
      r_state <= w_next_state;
      r_cnt   <= w_next_cnt;
      if (w_load_bubble) begin
        r_ex_valid    <= 1'b0;
        r_ex_ctrl     <= CTRL_W'(CTRL_BUBBLE);
        r_ex_src_a    <= '0;
        r_ex_src_b    <= '0;
        r_ex_agu_addr <= '0;
        r_ex_rd_dst   <= REG_SEL_W'(REG_ZERO);
        r_ex_mem_rd   <= 1'b0;
        r_ex_halt     <= 1'b0;
      end else begin
        r_ex_valid    <= i_id_valid;
        r_ex_ctrl     <= i_id_ctrl;
        r_ex_src_a    <= i_id_src_a;
        r_ex_src_b    <= i_id_src_b;
        r_ex_agu_addr <= i_id_agu_addr;
        r_ex_rd_dst   <= i_id_rd_dst;
        r_ex_mem_rd   <= i_id_mem_rd;
        r_ex_halt     <= i_id_halt;
      end
    end
  end

`ifdef HAZARD_PERF_EN
  logic [15:0] r_bubble_cnt;

  // Counts hazard and stall bubbles only; flush and HALT bubbles are excluded.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_bubble_cnt <= '0;
    end else if (i_step && w_count_bubble && (r_bubble_cnt != 16'hFFFF)) begin
      r_bubble_cnt <= r_bubble_cnt + 16'd1;
    end
  end

  assign o_bubble_cnt = r_bubble_cnt;
`else
  logic w_unused_perf;
  assign w_unused_perf = w_count_bubble;
  assign o_bubble_cnt  = '0;
`endif

  assign o_stall_if_id = w_stall;
  assign o_ex_valid    = r_ex_valid;
  assign o_ex_ctrl     = r_ex_ctrl;
  assign o_ex_src_a    = r_ex_src_a;
  assign o_ex_src_b    = r_ex_src_b;
  assign o_ex_agu_addr = r_ex_agu_addr;
  assign o_ex_rd_dst   = r_ex_rd_dst;
  assign o_ex_mem_rd   = r_ex_mem_rd;
  assign o_ex_halt     = r_ex_halt;
  assign o_halted      = (r_state == ST_HALT);

endmodule

// File: doc/id_ex_hazard_reg.md
Name: id_ex_hazard_reg

Overview:
Parametrised decode-to-execute pipeline register with an integrated load-use hazard unit, branch flush and halt latch for the MIPS pipeline. It registers the decoded operands and packed control bundle into EX. It stalls IF/ID and inserts a configurable number of bubbles on load-use hazards. It honours the debug single-step gate and freezes the pipe after a HALT.

Parameters:
NBITS, 32, datapath width of operand/address fields
REG_SEL_W, 5, register-select width (log2 of register count)
CTRL_W, 24, width of the packed control bundle from Control_Unit
LOAD_USE_BUBBLES, 1, bubbles inserted per load-use hazard (legal 1..7)

Ports:
i_clk  in  1  clock
i_rst  in  1  reset, asynchronous, active-low
i_step  in  1  debug advance enable; state updates only when 1
i_flush  in  1  taken jump/branch from a later stage; kill ID/EX contents
i_id_valid  in  1  ID holds a real instruction
i_id_rs, i_id_rt  in  REG_SEL_W  source selects of the ID instruction
i_id_uses_rs, i_id_uses_rt  in  1  ID instruction reads rs / rt
i_id_rd_dst  in  REG_SEL_W  destination register of the ID instruction
i_id_mem_rd  in  1  ID instruction is a load
i_id_halt  in  1  ID instruction is HALT
i_id_ctrl  in  CTRL_W  packed control flags
i_id_src_a, i_id_src_b, i_id_agu_addr  in  NBITS  operand / AGU base values
o_stall_if_id  out  1  hold PC and IF/ID register (combinational)
o_ex_valid  out  1  EX holds a real instruction
o_ex_ctrl  out  CTRL_W  registered control bundle
o_ex_src_a, o_ex_src_b, o_ex_agu_addr  out  NBITS  registered operands
o_ex_rd_dst  out  REG_SEL_W  registered destination
o_ex_mem_rd  out  1  registered load flag
o_ex_halt  out  1  registered HALT flag
o_halted  out  1  pipeline frozen by HALT
o_bubble_cnt  out  16  bubbles inserted (see Optional Feature)

Behaviour:
- Reset (i_rst=0, async): all registered outputs 0, state RUN, stall counter 0. o_stall_if_id then evaluates to 0.
- i_step=0: no register or state changes. o_stall_if_id still reflects current state and inputs.
- Latency: ID to EX is one i_clk edge with i_step=1.
- Bubble: o_ex_valid, o_ex_ctrl, o_ex_mem_rd, o_ex_halt all 0. Data fields and o_ex_rd_dst are zeroed.
- Hazard term: i_id_valid & o_ex_valid & o_ex_mem_rd & (o_ex_rd_dst != 0) & ((i_id_uses_rs & i_id_rs == o_ex_rd_dst) | (i_id_uses_rt & i_id_rt == o_ex_rd_dst)).
- States:
  - RUN:
    - No hazard: load ID fields (valid = i_id_valid). Stall 0.
    - Hazard: stall=1 and load a bubble.
    - Hazard with LOAD_USE_BUBBLES=1: stay RUN. The next cycle sees a bubble in EX, so there is no re-detect.
    - Hazard with LOAD_USE_BUBBLES>1: cnt <= LOAD_USE_BUBBLES-1, go to STALL.
  - STALL: stall=1, load a bubble, cnt decrements. When cnt==1 the next state is RUN.
  - HALT: entered on the edge after a valid HALT is loaded into EX. stall=1, bubbles every step, o_halted=1. Exit only by reset.
- Flush (i_flush=1 with i_step=1): highest priority. EX loads a bubble, cnt cleared, STALL returns to RUN, and a HALT sitting in ID is discarded. Flush in HALT state is ignored. o_stall_if_id is 0 during a flush cycle.
- Hazard against a destination of 0 is never raised.

Optional Feature:
HAZARD_PERF_EN
- Defined: o_bubble_cnt increments by 1 on each step edge that loads a hazard or stall bubble. Flush bubbles are not counted. The counter saturates at 16'hFFFF and is cleared by reset.
- Undefined: o_bubble_cnt is tied to 0 and no counter flops exist.

Decomposition:
- Package id_pkg holds:
  - state enum RUN/STALL/HALT
  - REG_ZERO constant
  - CTRL_BUBBLE constant (all zeros, CTRL_W wide)
  - stall counter width constant $clog2(8)
- Sub-module load_use_detector: the combinational hazard term, reused by the future forwarding unit.

Test Plan:
- No hazard: ADD (rs=2, rt=3) follows a load to r5 -> o_ex_valid=1 next edge, stall never asserted.
- Load-use with LOAD_USE_BUBBLES=1: LW r5 in EX, ID uses rs=5 -> stall=1 for 1 cycle, one bubble, instruction enters EX on the second edge.
- Load-use with LOAD_USE_BUBBLES=3: same stimulus -> stall high for 3 steps, 3 bubbles, o_bubble_cnt=3 with HAZARD_PERF_EN.
- Flush during STALL (LOAD_USE_BUBBLES=3, flush on the 2nd step) -> bubble loaded, state RUN, stall=0 that cycle.
- HALT then further instructions -> o_ex_halt=1 one cycle, o_halted=1 afterwards, o_stall_if_id=1 permanently. i_rst low mid-HALT -> all outputs 0 immediately.
- i_step=0 with a hazard present -> outputs frozen and stall=1 visible; resumes correctly when i_step returns to 1.
